// File: rtl/usb_rx_pkg.sv
// Shared types and default sizing for the USB receive deserializer.
package usb_rx_pkg;

    // Receive FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_ERR  = 2'd2
    } rx_state_t;

    // Default word width in bits
    localparam int DEFAULT_DATA_W    = 8;
    // Default run of decoded ones that is followed by a stuffed bit
    localparam int DEFAULT_STUFF_LEN = 6;

endpackage : usb_rx_pkg

// File: rtl/usb_nrzi_dec.sv
// NRZI decoder: a line level equal to the previous sampled level decodes as 1,
// a transition decodes as 0. The reference level follows the line on every
// sample strobe and returns to the idle (J = 1) level at end of packet.
import usb_rx_pkg::*;

module usb_nrzi_dec (
    input  logic clk,
    input  logic rst,
    input  logic d_plus_sync,
    input  logic shift_enable,
    input  logic eop,
    output logic nrzi_bit
);

    logic prev_level_reg;

    // Track the line level at each sample strobe; end of packet restores idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_level_reg <= 1'b1;
        end else if (shift_enable) begin
            prev_level_reg <= eop ? 1'b1 : d_plus_sync;
        end
    end

    assign nrzi_bit = ~(d_plus_sync ^ prev_level_reg);

endmodule : usb_nrzi_dec

// File: rtl/usb_rx_deserializer.sv
// USB receive deserializer: NRZI decode, bit-unstuffing and word assembly
// (LSB first) with a one-deep output holding register and error pulses.
// Optional feature macro USB_STUFF_ERR_EN: when defined, a stuffed-bit slot
// that decodes as 1 raises stuff_err and parks the FSM in ERR until the packet
// ends. When undefined the stuffed slot is dropped unchecked and stuff_err is 0.
import usb_rx_pkg::*;

module usb_rx_deserializer #(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int STUFF_LEN = DEFAULT_STUFF_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_plus_sync,
    input  logic              shift_enable,
    input  logic              eop,
    input  logic              rx_en,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_done,
    output logic              stuff_err,
    output logic              align_err,
    output logic              overrun
);

    localparam int BIT_W  = $clog2(DATA_W);
    localparam int ONES_W = $clog2(STUFF_LEN + 1);

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [ONES_W-1:0] STUFF_CNT = ONES_W'(STUFF_LEN);

    rx_state_t          state_reg, state_next;
    logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [ONES_W-1:0]  ones_cnt_reg, ones_cnt_next;
    logic [DATA_W-1:0]  word_reg, word_next;
    logic [DATA_W-1:0]  word_asm;
    logic [DATA_W-1:0]  rx_data_reg, rx_data_next;
    logic               rx_valid_reg, rx_valid_next;
    logic               rx_done_reg, rx_done_next;
    logic               align_err_reg, align_err_next;
    logic               overrun_reg, overrun_next;
    logic               word_complete;
`ifdef USB_STUFF_ERR_EN
    logic               stuff_err_reg, stuff_err_next;
`endif

    logic nrzi_bit;
    logic pkt_end;
    logic bit_strobe;

    usb_nrzi_dec u_nrzi_dec (
        .clk          (clk),
        .rst          (rst),
        .d_plus_sync  (d_plus_sync),
        .shift_enable (shift_enable),
        .eop          (eop),
        .nrzi_bit     (nrzi_bit)
    );

    // An EOP strobe ends the packet; any other strobe carries a line bit
    assign pkt_end    = shift_enable & eop;
    assign bit_strobe = shift_enable & ~eop;

    // Word as it would look with the current decoded bit written at bit_cnt;
    // on the last bit this is the completed word handed to the output stage
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_word_asm
            assign word_asm[gi] = (bit_cnt_reg == BIT_W'(gi)) ? nrzi_bit : word_reg[gi];
        end
    endgenerate

    // Next-state, counter and output-stage logic
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        ones_cnt_next  = ones_cnt_reg;
        word_next      = word_reg;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = rx_valid_reg;
        rx_done_next   = 1'b0;
        align_err_next = 1'b0;
        overrun_next   = 1'b0;
        word_complete  = 1'b0;
`ifdef USB_STUFF_ERR_EN
        stuff_err_next = 1'b0;
`endif

        // Consumer takes the held word on this edge
        if (rx_valid_reg && rx_ready) begin
            rx_valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                bit_cnt_next  = '0;
                ones_cnt_next = '0;
                if (rx_en) begin
                    state_next = ST_RX;
                end
            end

            ST_RX: begin
                if (pkt_end) begin
                    // Packet closed; a partially filled word is thrown away
                    state_next     = ST_IDLE;
                    bit_cnt_next   = '0;
                    ones_cnt_next  = '0;
                    word_next      = '0;
                    rx_done_next   = 1'b1;
                    align_err_next = (bit_cnt_reg != '0);
                end else if (!rx_en) begin
                    // Receive window closed early: silent discard
                    state_next    = ST_IDLE;
                    bit_cnt_next  = '0;
                    ones_cnt_next = '0;
                    word_next     = '0;
                end else if (bit_strobe) begin
                    if (ones_cnt_reg == STUFF_CNT) begin
                        // Stuffed-bit slot: never part of the data
                        ones_cnt_next = '0;
`ifdef USB_STUFF_ERR_EN
                        if (nrzi_bit) begin
                            stuff_err_next = 1'b1;
                            state_next     = ST_ERR;
                            bit_cnt_next   = '0;
                            word_next      = '0;
                        end
`endif
                    end else begin
                        ones_cnt_next = nrzi_bit ? (ones_cnt_reg + ONES_W'(1)) : '0;
                        word_next     = word_asm;
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_next  = '0;
                            word_complete = 1'b1;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                        end
                    end
                end
            end

            ST_ERR: begin
                // Ignore the rest of a corrupted packet
                bit_cnt_next  = '0;
                ones_cnt_next = '0;
                if (pkt_end) begin
                    state_next   = ST_IDLE;
                    rx_done_next = 1'b1;
                end else if (!rx_en) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next    = ST_IDLE;
                bit_cnt_next  = '0;
                ones_cnt_next = '0;
            end
        endcase

        // Hand a finished word to the output register unless it is still occupied
        if (word_complete) begin
            if (rx_valid_reg && !rx_ready) begin
                overrun_next = 1'b1;
            end else begin
                rx_data_next  = word_asm;
                rx_valid_next = 1'b1;
            end
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            ones_cnt_reg  <= '0;
            word_reg      <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            rx_done_reg   <= 1'b0;
            align_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
`ifdef USB_STUFF_ERR_EN
            stuff_err_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            ones_cnt_reg  <= ones_cnt_next;
            word_reg      <= word_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            rx_done_reg   <= rx_done_next;
            align_err_reg <= align_err_next;
            overrun_reg   <= overrun_next;
`ifdef USB_STUFF_ERR_EN
            stuff_err_reg <= stuff_err_next;
`endif
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign rx_done   = rx_done_reg;
    assign align_err = align_err_reg;
    assign overrun   = overrun_reg;
`ifdef USB_STUFF_ERR_EN
    assign stuff_err = stuff_err_reg;
`else
    assign stuff_err = 1'b0;
`endif

endmodule : usb_rx_deserializer

// File: tb/tb_usb_rx_deserializer.sv
// Self-checking bench for usb_rx_deserializer. Bits are NRZI-encoded and
// bit-stuffed by the bench; expected words go into a scoreboard queue when the
// final bit is driven and are compared when the consumer takes the word.
// The stuff-error scenario is built only with USB_STUFF_ERR_EN defined.
module tb_usb_rx_deserializer;

    localparam int DATA_W    = 8;
    localparam int STUFF_LEN = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              d_plus_sync = 1'b1;
    logic              shift_enable = 1'b0;
    logic              eop = 1'b0;
    logic              rx_en = 1'b0;
    logic              rx_ready = 1'b1;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_done;
    logic              stuff_err;
    logic              align_err;
    logic              overrun;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] exp_q[$];

    // pulse counters observed by the monitor, and the bench's expectations
    int done_cnt = 0, align_cnt = 0, align_done_cnt = 0, overrun_cnt = 0, stuff_cnt = 0;
    int exp_done = 0, exp_align = 0, exp_overrun = 0, exp_stuff = 0;

    // encoder state
    logic line_level = 1'b1;
    int   ones_run   = 0;
    logic ready_flag = 1'b0;

    usb_rx_deserializer #(
        .DATA_W    (DATA_W),
        .STUFF_LEN (STUFF_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .d_plus_sync  (d_plus_sync),
        .shift_enable (shift_enable),
        .eop          (eop),
        .rx_en        (rx_en),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_done      (rx_done),
        .stuff_err    (stuff_err),
        .align_err    (align_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Monitor: count pulses and score words as the consumer takes them
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_done) done_cnt++;
            if (align_err) begin
                align_cnt++;
                if (rx_done) align_done_cnt++;
            end
            if (overrun) overrun_cnt++;
            if (stuff_err) stuff_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check_value("sb_pending", exp_q.size(), 32'd1);
                end else begin
                    check_value("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // One sample strobe with the line held at the given level
    task automatic strobe(input logic level, input logic eop_v);
        repeat (3) @(posedge clk);
        #1;
        d_plus_sync  = level;
        eop          = eop_v;
        shift_enable = 1'b1;
        if (ready_flag) rx_ready = 1'b1;
        @(posedge clk);
        #1;
        shift_enable = 1'b0;
        eop          = 1'b0;
    endtask

    // NRZI-encode one data bit, inserting a stuffed 0 after a run of ones
    task automatic send_bit(input logic b);
        line_level = b ? line_level : ~line_level;
        strobe(line_level, 1'b0);
        ones_run = b ? ones_run + 1 : 0;
        if (ones_run == STUFF_LEN) begin
            line_level = ~line_level;
            strobe(line_level, 1'b0);
            ones_run = 0;
        end
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input bit push, input bit ready_at_last);
        for (int i = 0; i < DATA_W; i++) begin
            if (i == DATA_W - 1) begin
                if (push) exp_q.push_back(w);
                ready_flag = ready_at_last;
            end
            send_bit(w[i]);
        end
        ready_flag = 1'b0;
    endtask

    task automatic start_packet();
        ones_run = 0;
    endtask

    task automatic end_packet();
        strobe(1'b0, 1'b1);
        d_plus_sync = 1'b1;
        line_level  = 1'b1;
        ones_run    = 0;
    endtask

    task automatic check_pulses(input string tag);
        repeat (4) @(posedge clk);
        #1;
        check_value({tag, "_done"},    done_cnt,    exp_done);
        check_value({tag, "_align"},   align_cnt,   exp_align);
        check_value({tag, "_overrun"}, overrun_cnt, exp_overrun);
        check_value({tag, "_stuff"},   stuff_cnt,   exp_stuff);
    endtask

    initial begin
        logic [DATA_W-1:0] w;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_valid", rx_valid, 1'b0);
        check_value("rst_data", rx_data, 8'h00);
        check_value("rst_pulses", {rx_done, align_err, overrun, stuff_err}, 4'b0000);
        rst = 1'b0;
        rx_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single byte 0xA5 with one-cycle output latency
        start_packet();
        w = 8'hA5;
        for (int i = 0; i < DATA_W - 1; i++) send_bit(w[i]);
        check_value("a5_pre_valid", rx_valid, 1'b0);
        exp_q.push_back(w);
        send_bit(w[DATA_W-1]);
        check_value("a5_latency_valid", rx_valid, 1'b1);
        check_value("a5_latency_data", rx_data, 8'hA5);
        end_packet();
        exp_done++;
        check_pulses("a5");

        // 0xFF then 0x01: a stuffed 0 follows the sixth one
        start_packet();
        send_word(8'hFF, 1, 0);
        send_word(8'h01, 1, 0);
        end_packet();
        exp_done++;
        check_pulses("stuff");

        // EOP after three bits: rx_done and align_err together, no word
        start_packet();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        end_packet();
        exp_done++;
        exp_align++;
        check_pulses("align");
        check_value("align_same_cycle", align_done_cnt, 1);
        check_value("align_no_valid", rx_valid, 1'b0);

        // overrun: second word dropped, third lands as the first is consumed
        rx_ready = 1'b0;
        start_packet();
        send_word(8'h11, 1, 0);
        send_word(8'h22, 0, 0);
        exp_overrun++;
        #1;
        check_value("ovr_keep_data", rx_data, 8'h11);
        check_value("ovr_keep_valid", rx_valid, 1'b1);
        send_word(8'h33, 1, 1);
        end_packet();
        exp_done++;
        check_pulses("overrun");

        // rx_en falls mid-word: silent discard, next packet clean
        start_packet();
        w = 8'hC3;
        for (int i = 0; i < 5; i++) send_bit(w[i]);
        rx_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rxen_drop_valid", rx_valid, 1'b0);
        rx_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start_packet();
        send_word(8'h96, 1, 0);
        end_packet();
        exp_done++;
        check_pulses("rxen");

`ifdef USB_STUFF_ERR_EN
        // stuffed slot decoding as 1: one stuff_err pulse, rest of packet ignored
        start_packet();
        for (int i = 0; i < STUFF_LEN + 1; i++) strobe(line_level, 1'b0);
        send_word(8'hAA, 0, 0);
        check_value("serr_no_valid", rx_valid, 1'b0);
        end_packet();
        exp_stuff++;
        exp_done++;
        check_pulses("serr");
        start_packet();
        send_word(8'h5C, 1, 0);
        end_packet();
        exp_done++;
        check_pulses("serr_recover");
`endif

        // asynchronous reset mid-word with a word still held
        rx_ready = 1'b0;
        start_packet();
        send_word(8'h5A, 0, 0);
        check_value("pre_rst_valid", rx_valid, 1'b1);
        w = 8'h3C;
        for (int i = 0; i < 4; i++) send_bit(w[i]);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_value("async_rst_valid", rx_valid, 1'b0);
        check_value("async_rst_data", rx_data, 8'h00);
        check_value("async_rst_pulses", {rx_done, align_err, overrun, stuff_err}, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        line_level  = 1'b1;
        d_plus_sync = 1'b1;
        rx_ready    = 1'b1;
        rst         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start_packet();
        send_word(8'h3C, 1, 0);
        end_packet();
        exp_done++;
        check_pulses("post_rst");

        repeat (4) @(posedge clk);
        #1;
        check_value("sb_drained", exp_q.size(), 32'd0);
        check_value("final_valid", rx_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_usb_rx_deserializer

// File: doc/usb_rx_deserializer.md
USB_RX_DESERIALIZER -- requirements
Module: usb_rx_deserializer

Interface
REQ-001 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W SHALL be: DATA_W, 8, deserialised word width in bits (4..32).
REQ-003 Parameter STUFF_LEN SHALL be: STUFF_LEN, 6, run of decoded ones after which one stuffed bit follows (2..15).
REQ-004 Port SHALL be: clk  in  1  system clock, rising edge.
REQ-005 Port SHALL be: rst  in  1  asynchronous active-high reset.
REQ-006 Port SHALL be: d_plus_sync  in  1  synchronised D+ line level.
REQ-007 Port SHALL be: shift_enable  in  1  one-cycle bit-sample strobe.
REQ-008 Port SHALL be: eop  in  1  end-of-packet seen; qualified by shift_enable.
REQ-009 Port SHALL be: rx_en  in  1  receive window open.
REQ-010 Port SHALL be: rx_ready  in  1  consumer accepts rx_data.
REQ-011 Port SHALL be: rx_data  out  DATA_W  assembled word, LSB received first.
REQ-012 Port SHALL be: rx_valid  out  1  rx_data holds an unconsumed word.
REQ-013 Port SHALL be: rx_done  out  1  one-cycle pulse, packet ended.
REQ-014 Port SHALL be: stuff_err, align_err, overrun  out  1 each  one-cycle error pulses.

Function
REQ-015 NRZI decode SHALL be: bit = ~(d_plus_sync ^ prev_level); prev_level updates to d_plus_sync only on shift_enable; forced to 1 on eop&shift_enable.
REQ-016 FSM SHALL have states IDLE, RX, ERR; IDLE->RX when rx_en=1; RX/ERR->IDLE on eop&shift_enable or rx_en=0; RX->ERR on stuff error.
REQ-017 ones_cnt SHALL increment on each decoded 1, clear on each decoded 0; when ones_cnt==STUFF_LEN the next sampled bit SHALL be discarded and ones_cnt cleared.
REQ-018 Non-stuffed bits in RX SHALL be written to word[bit_cnt]; bit_cnt wraps DATA_W-1 -> 0.
REQ-019 On the write of bit DATA_W-1, rx_data and rx_valid=1 SHALL update on the next clock edge (latency 1 cycle from final strobe).
REQ-020 rx_valid SHALL hold until a cycle with rx_ready=1; the word is consumed on that edge.
REQ-021 Word completion while rx_valid=1 and rx_ready=0 SHALL pulse overrun, drop the new word, keep old rx_data.
REQ-022 Completion coincident with rx_ready=1 SHALL load the new word and keep rx_valid=1.
REQ-023 eop&shift_enable SHALL pulse rx_done next cycle; if bit_cnt!=0 it SHALL also pulse align_err and discard the partial word.
REQ-024 In IDLE and ERR decoded bits SHALL be ignored; counters held at 0; prev_level still tracks the line.
REQ-025 rx_en falling mid-word SHALL discard the partial word without error pulses.

Reset
REQ-026 rst SHALL force IDLE, prev_level=1, counters=0, rx_data=0, rx_valid=0, all pulses=0, immediately and asynchronously, including mid-packet.

Configuration
REQ-027 With USB_STUFF_ERR_EN defined, a stuffed-bit slot decoding as 1 SHALL pulse stuff_err and enter ERR.
REQ-028 Without USB_STUFF_ERR_EN, the stuffed slot SHALL be discarded unchecked; stuff_err tied 0; ERR unreachable.

Structure
REQ-029 Package usb_rx_pkg SHALL hold the FSM state enum and default DATA_W/STUFF_LEN constants.
REQ-030 Sub-module usb_nrzi_dec SHALL hold prev_level and the decode of REQ-015.
REQ-031 Counter widths SHALL be $clog2(DATA_W) and $clog2(STUFF_LEN+1).

Verification
REQ-032 Reset; rx_en=1; send byte 0xA5 NRZI, LSB first -> rx_valid=1 one cycle after 8th strobe, rx_data=0xA5.
REQ-033 Send 0xFF,0x01 with stuffed 0 after six 1s -> words 0xFF,0x01; no stuff_err.
REQ-034 With USB_STUFF_ERR_EN, stuffed slot =1 -> stuff_err one pulse, FSM ERR, no rx_valid until next packet.
REQ-035 rx_ready=0, two full words -> overrun pulse, rx_data keeps first word.
REQ-036 eop after 3 bits -> rx_done and align_err same cycle, no rx_valid.
REQ-037 Assert rst mid-word -> all outputs 0 same cycle; next 0x3C packet decodes cleanly.
